rv_mc_ctrl_fsm: RTL and testbench

//  Multi-cycle RV32I control FSM, successor to the single-mode CU: full branch set (beq/bne/blt/bge/bltu/bgeu),

---
 rtl/rv_mc_ctrl_fsm.sv | 241 ++++++++++++++++++++++++
 tb/tb_rv_mc_ctrl_fsm.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mc_ctrl_fsm.sv
// rtl/rv_mc_ctrl_fsm.sv - multi-cycle RV32I control FSM driving the datapath strobes and muxes
//
// Purpose: this block decodes the IR fields (opcode/funct3/funct7) and walks each instruction
// through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux
// select. All outputs are registered and are decoded from the next state, so a strobe is high in
// the same cycle that its state is occupied. Mux selects that a state does not name keep their
// previous value. Strobes that a state does not name are 0.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   opcode, funct3, funct7  IR fields
//   zf, lt, ltu             ALU flags: zero, signed rs1<rs2, unsigned rs1<rs2
//   mem_ready               data memory access complete
//   alu_op                  ALU operation {funct7[5],funct3}; ADD=0000, SUB=1000
//   rs2_imm_s, alu_a_s      ALU B select (rs2/imm), ALU A select (rs1/PC0)
//   w_data_s                regfile data select: ALU, imm, mem rdata, PC (link)
//   reg_write, ir_write     regfile write strobe, IR load
//   pc_write, pc0_write     PC load, PC0 load
//   pc_s                    PC source: PC+4, PC0+imm, ALU&~1
//   mem_read, mem_write     data memory requests
//   illegal                 sticky illegal-instruction flag
//   state_o                 current state code (debug)
module rv_mc_ctrl_fsm #(
   parameter bit MEM_WAIT_EN     = 1'b1,
   parameter bit HALT_ON_ILLEGAL = 1'b1,
   parameter int ALU_OP_W        = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic [6:0]          funct7,
   input  logic                zf,
   input  logic                lt,
   input  logic                ltu,
   input  logic                mem_ready,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                rs2_imm_s,
   output logic                alu_a_s,
   output logic [1:0]          w_data_s,
   output logic                reg_write,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc0_write,
   output logic [1:0]          pc_s,
   output logic                mem_read,
   output logic                mem_write,
   output logic                illegal,
   output logic [4:0]          state_o
);
   // The numeric state codes appear on state_o, so they are part of the debug interface.
   typedef enum logic [4:0] {
      S_IDLE = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2, S_EXEC_R = 5'd3, S_EXEC_I = 5'd4,
      S_WB_ALU = 5'd5, S_LUI = 5'd6, S_AUIPC = 5'd7, S_ADDR = 5'd8, S_MEM_RD = 5'd9,
      S_WB_MEM = 5'd10, S_MEM_WR = 5'd11, S_JAL = 5'd12, S_JALR_A = 5'd13, S_JALR_W = 5'd14,
      S_BR_CMP = 5'd15, S_BR_TAKE = 5'd16, S_TRAP = 5'd17
   } state_t;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = '0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'b1000);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t              state, state_nx;
   logic [ALU_OP_W-1:0] alu_op_nx;
   logic                rs2_imm_s_nx, alu_a_s_nx, reg_write_nx, ir_write_nx, pc_write_nx;
   logic                pc0_write_nx, mem_read_nx, mem_write_nx, illegal_nx, br_taken;
   logic [1:0]          w_data_s_nx, pc_s_nx;

   // Only funct7[5] takes part in the decode.
   logic unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   assign state_o = state;

   // State and registered outputs. Because the reset is asynchronous, a strobe that is in flight
   // (for example mem_write during a wait) drops as soon as rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         alu_op    <= '0;
         rs2_imm_s <= 1'b0;
         alu_a_s   <= 1'b0;
         w_data_s  <= 2'b00;
         reg_write <= 1'b0;
         ir_write  <= 1'b0;
         pc_write  <= 1'b0;
         pc0_write <= 1'b0;
         pc_s      <= 2'b00;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state     <= state_nx;
         alu_op    <= alu_op_nx;
         rs2_imm_s <= rs2_imm_s_nx;
         alu_a_s   <= alu_a_s_nx;
         w_data_s  <= w_data_s_nx;
         reg_write <= reg_write_nx;
         ir_write  <= ir_write_nx;
         pc_write  <= pc_write_nx;
         pc0_write <= pc0_write_nx;
         pc_s      <= pc_s_nx;
         mem_read  <= mem_read_nx;
         mem_write <= mem_write_nx;
         illegal   <= illegal_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   state_nx = S_FETCH;
         S_FETCH:  state_nx = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:      state_nx = S_EXEC_R;
               OP_I:      state_nx = S_EXEC_I;
               OP_LUI:    state_nx = S_LUI;
               OP_AUIPC:  state_nx = S_AUIPC;
               OP_LOAD,
               OP_STORE:  state_nx = (funct3 == 3'b010) ? S_ADDR : S_TRAP;
               OP_JAL:    state_nx = S_JAL;
               OP_JALR:   state_nx = (funct3 == 3'b000) ? S_JALR_A : S_TRAP;
               OP_BRANCH: state_nx = (funct3[2:1] == 2'b01) ? S_TRAP : S_BR_CMP;
               default:   state_nx = S_TRAP;
            endcase
         end
         S_EXEC_R, S_EXEC_I, S_AUIPC: state_nx = S_WB_ALU;
         // The IR is still valid here, and opcode bit 5 separates sw from lw.
         S_ADDR:   state_nx = opcode[5] ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: state_nx = (mem_ready || !MEM_WAIT_EN) ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR: state_nx = (mem_ready || !MEM_WAIT_EN) ? S_FETCH : S_MEM_WR;
         S_JALR_A: state_nx = S_JALR_W;
         S_BR_CMP: state_nx = S_BR_TAKE;
         S_TRAP:   state_nx = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
         S_WB_ALU, S_LUI, S_WB_MEM, S_JAL, S_JALR_W, S_BR_TAKE: state_nx = S_FETCH;
         default:  state_nx = S_IDLE;
      endcase
   end

   // The flags are evaluated on the BR_CMP->BR_TAKE edge, which is when the SUB result is live.
   always_comb begin
      case (funct3)
         3'b000:  br_taken = zf;
         3'b001:  br_taken = ~zf;
         3'b100:  br_taken = lt;
         3'b101:  br_taken = ~lt;
         3'b110:  br_taken = ltu;
         3'b111:  br_taken = ~ltu;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      alu_op_nx    = alu_op;
      rs2_imm_s_nx = rs2_imm_s;
      alu_a_s_nx   = alu_a_s;
      w_data_s_nx  = w_data_s;
      pc_s_nx      = pc_s;
      illegal_nx   = illegal;
      reg_write_nx = 1'b0;
      ir_write_nx  = 1'b0;
      pc_write_nx  = 1'b0;
      pc0_write_nx = 1'b0;
      mem_read_nx  = 1'b0;
      mem_write_nx = 1'b0;
      case (state_nx)
         S_FETCH: begin
            pc_write_nx  = 1'b1;
            ir_write_nx  = 1'b1;
            pc0_write_nx = 1'b1;
            pc_s_nx      = 2'b00;
            alu_a_s_nx   = 1'b0;
         end
         S_EXEC_R: begin
            rs2_imm_s_nx = 1'b0;
            alu_op_nx    = ALU_OP_W'({funct7[5], funct3});
         end
         // In the I-type group, funct7[5] is meaningful only for shifts right (srli/srai).
         // For every other I-type op that bit position belongs to the immediate.
         S_EXEC_I: begin
            rs2_imm_s_nx = 1'b1;
            alu_op_nx    = ALU_OP_W'({(funct3 == 3'b101) & funct7[5], funct3});
         end
         S_WB_ALU: begin
            reg_write_nx = 1'b1;
            w_data_s_nx  = 2'b00;
         end
         S_LUI: begin
            reg_write_nx = 1'b1;
            w_data_s_nx  = 2'b01;
         end
         S_AUIPC: begin
            alu_a_s_nx   = 1'b1;
            rs2_imm_s_nx = 1'b1;
            alu_op_nx    = ALU_ADD;
         end
         S_ADDR, S_JALR_A: begin
            rs2_imm_s_nx = 1'b1;
            alu_op_nx    = ALU_ADD;
         end
         S_MEM_RD: mem_read_nx  = 1'b1;
         S_MEM_WR: mem_write_nx = 1'b1;
         S_WB_MEM: begin
            reg_write_nx = 1'b1;
            w_data_s_nx  = 2'b10;
         end
         S_JAL: begin
            reg_write_nx = 1'b1;
            w_data_s_nx  = 2'b11;
            pc_write_nx  = 1'b1;
            pc_s_nx      = 2'b01;
         end
         S_JALR_W: begin
            reg_write_nx = 1'b1;
            w_data_s_nx  = 2'b11;
            pc_write_nx  = 1'b1;
            pc_s_nx      = 2'b10;
         end
         S_BR_CMP: begin
            rs2_imm_s_nx = 1'b0;
            alu_op_nx    = ALU_SUB;
         end
         S_BR_TAKE: begin
            pc_s_nx     = 2'b01;
            pc_write_nx = br_taken;
         end
         S_TRAP:  illegal_nx = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_rv_mc_ctrl_fsm.sv
// tb/tb_rv_mc_ctrl_fsm.sv - scoreboard bench for rv_mc_ctrl_fsm (default and no-wait/no-halt builds)
module tb_rv_mc_ctrl_fsm;
   localparam int ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3, ST_EXEC_I = 4, ST_WB_ALU = 5;
   localparam int ST_LUI = 6, ST_AUIPC = 7, ST_ADDR = 8, ST_MEM_RD = 9, ST_WB_MEM = 10;
   localparam int ST_MEM_WR = 11, ST_JAL = 12, ST_JALR_A = 13, ST_JALR_W = 14;
   localparam int ST_BR_CMP = 15, ST_BR_TAKE = 16, ST_TRAP = 17;

   // strobes {reg_write, ir_write, pc_write, pc0_write, mem_read, mem_write, illegal}
   localparam logic [6:0] S_NONE = 7'b0000000, S_FETCH = 7'b0111000, S_RW = 7'b1000000;
   localparam logic [6:0] S_MR = 7'b0000100, S_MW = 7'b0000010, S_JUMP = 7'b1010000;
   localparam logic [6:0] S_PCW = 7'b0010000, S_ILL = 7'b0000001;
   // mux selects {alu_op[3:0], rs2_imm_s, alu_a_s, w_data_s[1:0], pc_s[1:0]}
   localparam logic [9:0] M_ALU = 10'b1111_0_0_00_00, M_RSI = 10'b0000_1_0_00_00;
   localparam logic [9:0] M_AAS = 10'b0000_0_1_00_00, M_WDS = 10'b0000_0_0_11_00;
   localparam logic [9:0] M_PCS = 10'b0000_0_0_00_11;

   typedef struct {
      string      tag;
      bit         alt;
      bit         rdy;
      logic [4:0] st;
      logic [6:0] strb;
      logic [9:0] mv;
      logic [9:0] mm;
   } ent_t;

   ent_t sb[$];
   int   total = 0;
   int   bad   = 0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic [6:0] funct7 = '0;
   logic       zf = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;

   logic [3:0] m_aop, a_aop;
   logic [1:0] m_wds, a_wds, m_pcs, a_pcs;
   logic [4:0] m_st, a_st;
   logic       m_rsi, m_aas, m_rw, m_irw, m_pcw, m_pc0w, m_mr, m_mw, m_ill;
   logic       a_rsi, a_aas, a_rw, a_irw, a_pcw, a_pc0w, a_mr, a_mw, a_ill;

   // {f3, zf, lt, ltu, taken}
   logic [6:0] br_tab [6] = '{7'b001_1_0_0_0, 7'b001_0_0_0_1, 7'b111_0_0_1_0,
                              7'b100_0_1_0_1, 7'b000_1_0_0_1, 7'b101_0_1_0_0};

   always #5 clk = ~clk;

   rv_mc_ctrl_fsm u_main (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .zf(zf), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .alu_op(m_aop), .rs2_imm_s(m_rsi), .alu_a_s(m_aas), .w_data_s(m_wds),
      .reg_write(m_rw), .ir_write(m_irw), .pc_write(m_pcw), .pc0_write(m_pc0w),
      .pc_s(m_pcs), .mem_read(m_mr), .mem_write(m_mw), .illegal(m_ill), .state_o(m_st)
   );

   rv_mc_ctrl_fsm #(.MEM_WAIT_EN(1'b0), .HALT_ON_ILLEGAL(1'b0), .ALU_OP_W(4)) u_alt (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .zf(zf), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .alu_op(a_aop), .rs2_imm_s(a_rsi), .alu_a_s(a_aas), .w_data_s(a_wds),
      .reg_write(a_rw), .ir_write(a_irw), .pc_write(a_pcw), .pc0_write(a_pc0w),
      .pc_s(a_pcs), .mem_read(a_mr), .mem_write(a_mw), .illegal(a_ill), .state_o(a_st)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] st_of(input bit alt);
      return alt ? a_st : m_st;
   endfunction

   function automatic logic [6:0] strb_of(input bit alt);
      return alt ? {a_rw, a_irw, a_pcw, a_pc0w, a_mr, a_mw, a_ill}
                 : {m_rw, m_irw, m_pcw, m_pc0w, m_mr, m_mw, m_ill};
   endfunction

   function automatic logic [9:0] mux_of(input bit alt);
      return alt ? {a_aop, a_rsi, a_aas, a_wds, a_pcs} : {m_aop, m_rsi, m_aas, m_wds, m_pcs};
   endfunction

   task automatic p(input string tag, input bit alt, input bit rdy, input int st,
                    input logic [6:0] strb, input logic [9:0] mv, input logic [9:0] mm);
      ent_t e;
      e.tag = tag; e.alt = alt; e.rdy = rdy; e.st = 5'(st);
      e.strb = strb; e.mv = mv; e.mm = mm;
      sb.push_back(e);
   endtask

   task automatic p_fetch(input string tag, input bit alt, input bit rdy, input bit ill);
      p(tag, alt, rdy, ST_FETCH, S_FETCH | {6'b0, ill}, 10'b0, M_PCS | M_AAS);
   endtask

   task automatic p_head(input string tag, input bit alt);
      p_fetch(tag, alt, 1'b0, 1'b0);
      p(tag, alt, 1'b0, ST_DECODE, S_NONE, 10'b0, 10'b0);
   endtask

   // Each entry drives mem_ready for one cycle, then checks the outcome of that cycle's edge.
   task automatic run();
      int n = 0;
      while (sb.size() > 0) begin
         ent_t e;
         e = sb.pop_front();
         mem_ready = e.rdy;
         @(posedge clk);
         #1;
         chk($sformatf("%s.%0d.state", e.tag, n), 32'(st_of(e.alt)), 32'(e.st));
         chk($sformatf("%s.%0d.strobes", e.tag, n), 32'(strb_of(e.alt)), 32'(e.strb));
         if (e.mm != 10'b0)
            chk($sformatf("%s.%0d.mux", e.tag, n), 32'(mux_of(e.alt) & e.mm), 32'(e.mv & e.mm));
         n++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rst.main", {m_st, strb_of(1'b0), mux_of(1'b0)}, 32'd0);
      chk("rst.alt", {a_st, strb_of(1'b1), mux_of(1'b1)}, 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      opcode = op; funct3 = f3; funct7 = f7;
   endtask

   task automatic alu_seq(input string tag, input int ex_st, input logic [9:0] ex_mv);
      p_head(tag, 1'b0);
      p(tag, 1'b0, 1'b0, ex_st, S_NONE, ex_mv, M_ALU | M_RSI);
      p(tag, 1'b0, 1'b0, ST_WB_ALU, S_RW, 10'b0, M_WDS);
      p_fetch(tag, 1'b0, 1'b0, 1'b0);
      run();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      do_reset(); set_ir(7'b0010011, 3'b000, 7'b0000000);
      alu_seq("addi", ST_EXEC_I, 10'b0000_1_0_00_00);
      do_reset(); set_ir(7'b0010011, 3'b101, 7'b0100000);
      alu_seq("srai", ST_EXEC_I, 10'b1101_1_0_00_00);
      do_reset(); set_ir(7'b0010011, 3'b000, 7'b0100000);
      alu_seq("addi_neg", ST_EXEC_I, 10'b0000_1_0_00_00);
      do_reset(); set_ir(7'b0110011, 3'b000, 7'b0100000);
      alu_seq("sub", ST_EXEC_R, 10'b1000_0_0_00_00);

      do_reset(); set_ir(7'b0110111, 3'b000, 7'b0);
      p_head("lui", 0);
      p("lui", 0, 0, ST_LUI, S_RW, 10'b0000_0_0_01_00, M_WDS);
      p_fetch("lui", 0, 0, 0);
      run();

      do_reset(); set_ir(7'b0010111, 3'b000, 7'b0);
      p_head("auipc", 0);
      p("auipc", 0, 0, ST_AUIPC, S_NONE, 10'b0000_1_1_00_00, M_ALU | M_RSI | M_AAS);
      p("auipc", 0, 0, ST_WB_ALU, S_RW, 10'b0000_0_1_00_00, M_WDS | M_AAS);
      p_fetch("auipc", 0, 0, 0);
      run();

      // lw with two wait cycles, then the same lw on the no-wait build
      do_reset(); set_ir(7'b0000011, 3'b010, 7'b0);
      p_head("lw_wait", 0);
      p("lw_wait", 0, 0, ST_ADDR, S_NONE, 10'b0000_1_0_00_00, M_ALU | M_RSI);
      p("lw_wait", 0, 0, ST_MEM_RD, S_MR, 10'b0, 10'b0);
      p("lw_wait", 0, 0, ST_MEM_RD, S_MR, 10'b0, 10'b0);
      p("lw_wait", 0, 0, ST_MEM_RD, S_MR, 10'b0, 10'b0);
      p("lw_wait", 0, 1, ST_WB_MEM, S_RW, 10'b0000_0_0_10_00, M_WDS);
      p_fetch("lw_wait", 0, 0, 0);
      run();
      do_reset();
      p_head("lw_nowait", 1);
      p("lw_nowait", 1, 0, ST_ADDR, S_NONE, 10'b0000_1_0_00_00, M_ALU | M_RSI);
      p("lw_nowait", 1, 0, ST_MEM_RD, S_MR, 10'b0, 10'b0);
      p("lw_nowait", 1, 0, ST_WB_MEM, S_RW, 10'b0000_0_0_10_00, M_WDS);
      p_fetch("lw_nowait", 1, 0, 0);
      run();

      do_reset(); set_ir(7'b0100011, 3'b010, 7'b0);
      p_head("sw_wait", 0);
      p("sw_wait", 0, 0, ST_ADDR, S_NONE, 10'b0000_1_0_00_00, M_ALU | M_RSI);
      p("sw_wait", 0, 0, ST_MEM_WR, S_MW, 10'b0, 10'b0);
      p("sw_wait", 0, 0, ST_MEM_WR, S_MW, 10'b0, 10'b0);
      p_fetch("sw_wait", 0, 1, 0);
      run();
      do_reset();
      p_head("sw_nowait", 1);
      p("sw_nowait", 1, 0, ST_ADDR, S_NONE, 10'b0000_1_0_00_00, M_ALU | M_RSI);
      p("sw_nowait", 1, 0, ST_MEM_WR, S_MW, 10'b0, 10'b0);
      p_fetch("sw_nowait", 1, 0, 0);
      run();

      // lb is not supported and must trap
      do_reset(); set_ir(7'b0000011, 3'b000, 7'b0);
      p_head("lb_trap", 0);
      p("lb_trap", 0, 0, ST_TRAP, S_ILL, 10'b0, 10'b0);
      run();

      for (int i = 0; i < 6; i++) begin
         logic [6:0] b;
         string      t;
         b = br_tab[i];
         t = $sformatf("br%0d_f3_%b", i, b[6:4]);
         do_reset(); set_ir(7'b1100011, b[6:4], 7'b0);
         zf = b[3]; lt = b[2]; ltu = b[1];
         p_head(t, 0);
         p(t, 0, 0, ST_BR_CMP, S_NONE, 10'b1000_0_0_00_00, M_ALU | M_RSI);
         p(t, 0, 0, ST_BR_TAKE, b[0] ? S_PCW : S_NONE, 10'b0000_0_0_00_01, M_PCS);
         p_fetch(t, 0, 0, 0);
         run();
      end
      zf = 1'b0; lt = 1'b0; ltu = 1'b0;

      do_reset(); set_ir(7'b1100011, 3'b011, 7'b0);
      p_head("br011_trap", 0);
      p("br011_trap", 0, 0, ST_TRAP, S_ILL, 10'b0, 10'b0);
      run();

      do_reset(); set_ir(7'b1100111, 3'b000, 7'b0);
      p_head("jalr", 0);
      p("jalr", 0, 0, ST_JALR_A, S_NONE, 10'b0000_1_0_00_00, M_ALU | M_RSI);
      p("jalr", 0, 0, ST_JALR_W, S_JUMP, 10'b0000_0_0_11_10, M_WDS | M_PCS);
      p_fetch("jalr", 0, 0, 0);
      run();

      do_reset(); set_ir(7'b1101111, 3'b000, 7'b0);
      p_head("jal", 0);
      p("jal", 0, 0, ST_JAL, S_JUMP, 10'b0000_0_0_11_01, M_WDS | M_PCS);
      p_fetch("jal", 0, 0, 0);
      run();

      do_reset(); set_ir(7'b1111111, 3'b000, 7'b0);
      p_head("trap_halt", 0);
      for (int i = 0; i < 21; i++) p("trap_halt", 0, 0, ST_TRAP, S_ILL, 10'b0, 10'b0);
      run();
      do_reset();
      p_head("trap_nohalt", 1);
      p("trap_nohalt", 1, 0, ST_TRAP, S_ILL, 10'b0, 10'b0);
      p_fetch("trap_nohalt", 1, 0, 1);
      p("trap_nohalt", 1, 0, ST_DECODE, S_ILL, 10'b0, 10'b0);
      run();

      // reset pulled mid-cycle while sw waits on memory
      do_reset(); set_ir(7'b0100011, 3'b010, 7'b0);
      p_head("sw_abort", 0);
      p("sw_abort", 0, 0, ST_ADDR, S_NONE, 10'b0000_1_0_00_00, M_ALU | M_RSI);
      p("sw_abort", 0, 0, ST_MEM_WR, S_MW, 10'b0, 10'b0);
      p("sw_abort", 0, 0, ST_MEM_WR, S_MW, 10'b0, 10'b0);
      run();
      #2 rst_n = 1'b0;
      #1;
      chk("arst.mem_write", 32'(m_mw), 32'd0);
      chk("arst.state", 32'(m_st), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      p_head("sw_restart", 0);
      p("sw_restart", 0, 0, ST_ADDR, S_NONE, 10'b0000_1_0_00_00, M_ALU | M_RSI);
      p("sw_restart", 0, 0, ST_MEM_WR, S_MW, 10'b0, 10'b0);
      p_fetch("sw_restart", 0, 1, 0);
      run();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
